// File: rtl/arbitro_escritura_banco_pkg.sv
// Shared widths and arbitration encoding for the register bank write path.
// Also holds the one-hot register decode used for pending-write tracking.
package arbitro_escritura_banco_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

  // One-hot decode of a register address
  function automatic logic [NREG-1:0] decode_reg(input logic [ADDR_W-1:0] addr);
    decode_reg = {{(NREG-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/ranura_escritura.sv
// One-entry write buffer for a single requester.
// A slot that is drained on an edge can accept a new request on that same edge.
module ranura_escritura
  import arbitro_escritura_banco_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dat,
  input  logic              drain,
  output logic              valid,
  output logic [ADDR_W-1:0] addr_q,
  output logic [DATA_W-1:0] dat_q,
  output logic              ack
);

  logic              valid_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] dat_r;
  logic              ack_r;
  logic              load_s;

  // Capture is allowed when the slot is empty or being emptied this edge
  always_comb begin
    load_s = req & (~valid_r | drain);
  end

  // Slot contents and one-cycle acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      dat_r   <= {DATA_W{1'b0}};
      ack_r   <= 1'b0;
    end else begin
      ack_r <= load_s;
      if (load_s) begin
        valid_r <= 1'b1;
        addr_r  <= addr;
        dat_r   <= dat;
      end else if (drain) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign valid  = valid_r;
  assign addr_q = addr_r;
  assign dat_q  = dat_r;
  assign ack    = ack_r;

endmodule

// File: rtl/arbitro_escritura_banco.sv
// Two-requester round-robin write arbiter feeding a single register bank port.
// Each requester has a one-entry buffer; one buffer drains per clock.
module arbitro_escritura_banco
  import arbitro_escritura_banco_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ReqA,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [DATA_W-1:0] DatA,
  input  logic              ReqB,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DatB,
  output logic              AckA,
  output logic              AckB,
  output logic [DATA_W-1:0] Dat,
  output logic [ADDR_W-1:0] R_W,
  output logic              E_N,
  output logic [NREG-1:0]   Pend,
  output logic              Busy
);

  logic              valid_a_s, valid_b_s;
  logic [ADDR_W-1:0] addr_a_s, addr_b_s;
  logic [DATA_W-1:0] dat_a_s, dat_b_s;
  logic              sel_a_s, sel_b_s;
  pri_t              state_r, state_nxt_s;
  logic              e_n_r;
  logic [ADDR_W-1:0] r_w_r;
  logic [DATA_W-1:0] dat_r;
  logic [NREG-1:0]   pend_s;

  ranura_escritura u_ranura_a (
    .clk   (Clk),
    .rst   (Rst),
    .req   (ReqA),
    .addr  (AddrA),
    .dat   (DatA),
    .drain (sel_a_s),
    .valid (valid_a_s),
    .addr_q(addr_a_s),
    .dat_q (dat_a_s),
    .ack   (AckA)
  );

  ranura_escritura u_ranura_b (
    .clk   (Clk),
    .rst   (Rst),
    .req   (ReqB),
    .addr  (AddrB),
    .dat   (DatB),
    .drain (sel_b_s),
    .valid (valid_b_s),
    .addr_q(addr_b_s),
    .dat_q (dat_b_s),
    .ack   (AckB)
  );

  // Grant selection and priority hand-over
  always_comb begin
    sel_a_s     = 1'b0;
    sel_b_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      PRI_A: begin
        if (valid_a_s) begin
          sel_a_s = 1'b1;
        end else begin
          sel_b_s = valid_b_s;
        end
      end
      PRI_B: begin
        if (valid_b_s) begin
          sel_b_s = 1'b1;
        end else begin
          sel_a_s = valid_a_s;
        end
      end
      default: begin
        sel_a_s = 1'b0;
        sel_b_s = 1'b0;
      end
    endcase
    if (sel_a_s) begin
      state_nxt_s = PRI_B;
    end else if (sel_b_s) begin
      state_nxt_s = PRI_A;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Priority state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= PRI_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bank port registers; address and data hold while idle
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      e_n_r <= 1'b0;
      r_w_r <= {ADDR_W{1'b0}};
      dat_r <= {DATA_W{1'b0}};
    end else begin
      e_n_r <= sel_a_s | sel_b_s;
      if (sel_a_s) begin
        r_w_r <= addr_a_s;
        dat_r <= dat_a_s;
      end else if (sel_b_s) begin
        r_w_r <= addr_b_s;
        dat_r <= dat_b_s;
      end
    end
  end

  // Pending map: buffered writes plus the write currently on the port
  always_comb begin
    pend_s = {NREG{1'b0}};
    if (valid_a_s) begin
      pend_s = pend_s | decode_reg(addr_a_s);
    end else begin
      pend_s = pend_s;
    end
    if (valid_b_s) begin
      pend_s = pend_s | decode_reg(addr_b_s);
    end else begin
      pend_s = pend_s;
    end
    if (e_n_r) begin
      pend_s = pend_s | decode_reg(r_w_r);
    end else begin
      pend_s = pend_s;
    end
  end

  assign E_N  = e_n_r;
  assign R_W  = r_w_r;
  assign Dat  = dat_r;
  assign Pend = pend_s;
  assign Busy = valid_a_s | valid_b_s | e_n_r;

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Directed self-checking bench for the write arbiter with a behavioural bank.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_arbitro_escritura_banco;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       ReqA, ReqB;
  logic [2:0] AddrA, AddrB;
  logic [7:0] DatA, DatB;
  logic       AckA, AckB;
  logic [7:0] Dat;
  logic [2:0] R_W;
  logic       E_N;
  logic [7:0] Pend;
  logic       Busy;

  logic [7:0] bank [8];
  int n_total = 0;
  int n_bad   = 0;

  arbitro_escritura_banco dut (
    .Clk(Clk), .Rst(Rst),
    .ReqA(ReqA), .AddrA(AddrA), .DatA(DatA),
    .ReqB(ReqB), .AddrB(AddrB), .DatB(DatB),
    .AckA(AckA), .AckB(AckB), .Dat(Dat), .R_W(R_W),
    .E_N(E_N), .Pend(Pend), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Register bank model written through the arbiter port
  always @(posedge Clk) begin
    if (!Rst && E_N) bank[R_W] <= Dat;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy && n < 20) begin
      tick();
      n++;
    end
    check_val(tag, 32'(Busy), 32'd0);
  endtask

  initial begin
    Rst = 1'b1;
    ReqA = 1'b0; AddrA = 3'd0; DatA = 8'd0;
    ReqB = 1'b0; AddrB = 3'd0; DatB = 8'd0;
    for (int i = 0; i < 8; i++) bank[i] = 8'd0;
    #2;
    check_val("rst_en",   32'(E_N),  32'd0);
    check_val("rst_acka", 32'(AckA), 32'd0);
    check_val("rst_ackb", 32'(AckB), 32'd0);
    check_val("rst_pend", 32'(Pend), 32'd0);
    check_val("rst_busy", 32'(Busy), 32'd0);
    check_val("rst_rw",   32'(R_W),  32'd0);
    check_val("rst_dat",  32'(Dat),  32'd0);
    tick();
    Rst = 1'b0;

    // Single write A -> R1 = 5
    ReqA = 1'b1; AddrA = 3'd1; DatA = 8'd5;
    tick();
    ReqA = 1'b0;
    check_val("s_acka",  32'(AckA), 32'd1);
    check_val("s_en0",   32'(E_N),  32'd0);
    check_val("s_pend0", 32'(Pend), 32'h02);
    check_val("s_busy0", 32'(Busy), 32'd1);
    tick();
    check_val("s_acka1", 32'(AckA), 32'd0);
    check_val("s_en1",   32'(E_N),  32'd1);
    check_val("s_rw1",   32'(R_W),  32'd1);
    check_val("s_dat1",  32'(Dat),  32'd5);
    check_val("s_pend1", 32'(Pend), 32'h02);
    tick();
    check_val("s_en2",   32'(E_N),  32'd0);
    check_val("s_bank1", 32'(bank[1]), 32'd5);
    check_val("s_pend2", 32'(Pend), 32'h00);
    check_val("s_busy2", 32'(Busy), 32'd0);
    check_val("s_dathold", 32'(Dat), 32'd5);

    // Contention: A (R2,6) and B (R4,7), fresh from reset so A first
    do_reset();
    ReqA = 1'b1; AddrA = 3'd2; DatA = 8'd6;
    ReqB = 1'b1; AddrB = 3'd4; DatB = 8'd7;
    tick();
    ReqA = 1'b0; ReqB = 1'b0;
    check_val("c_acka",  32'(AckA), 32'd1);
    check_val("c_ackb",  32'(AckB), 32'd1);
    check_val("c_pend0", 32'(Pend), 32'h14);
    tick();
    check_val("c_en1",   32'(E_N),  32'd1);
    check_val("c_rw1",   32'(R_W),  32'd2);
    check_val("c_dat1",  32'(Dat),  32'd6);
    check_val("c_pend1", 32'(Pend), 32'h14);
    tick();
    check_val("c_rw2",   32'(R_W),  32'd4);
    check_val("c_dat2",  32'(Dat),  32'd7);
    check_val("c_pend2", 32'(Pend), 32'h10);
    tick();
    check_val("c_en3",   32'(E_N),  32'd0);
    check_val("c_pend3", 32'(Pend), 32'h00);
    check_val("c_bank2", 32'(bank[2]), 32'd6);
    check_val("c_bank4", 32'(bank[4]), 32'd7);

    // Serve A once so priority favours B, then same-target contention on R6
    ReqA = 1'b1; AddrA = 3'd0; DatA = 8'h11;
    tick();
    ReqA = 1'b0;
    tick();
    tick();
    check_val("t_bank0", 32'(bank[0]), 32'h11);
    ReqA = 1'b1; AddrA = 3'd6; DatA = 8'd3;
    ReqB = 1'b1; AddrB = 3'd6; DatB = 8'd9;
    tick();
    ReqA = 1'b0; ReqB = 1'b0;
    tick();
    check_val("t_rw1",  32'(R_W), 32'd6);
    check_val("t_dat1", 32'(Dat), 32'd9);
    tick();
    check_val("t_dat2",  32'(Dat), 32'd3);
    check_val("t_bank6a", 32'(bank[6]), 32'd9);
    tick();
    check_val("t_bank6b", 32'(bank[6]), 32'd3);

    // Saturation: both held high, data steps on every ack
    do_reset();
    ReqA = 1'b1; AddrA = 3'd3; DatA = 8'h10;
    ReqB = 1'b1; AddrB = 3'd5; DatB = 8'h80;
    tick();
    check_val("q_acka0", 32'(AckA), 32'd1);
    check_val("q_ackb0", 32'(AckB), 32'd1);
    check_val("q_en0",   32'(E_N),  32'd0);
    if (AckA) DatA = DatA + 8'd1;
    if (AckB) DatB = DatB + 8'd1;
    for (int j = 0; j < 8; j++) begin
      int e_d;
      int e_a;
      e_d = ((j % 2) == 0) ? (16 + j / 2) : (128 + j / 2);
      e_a = ((j % 2) == 0) ? 3 : 5;
      tick();
      check_val("q_en",   32'(E_N),  32'd1);
      check_val("q_rw",   32'(R_W),  32'(e_a));
      check_val("q_dat",  32'(Dat),  32'(e_d));
      check_val("q_acka", 32'(AckA), 32'(((j % 2) == 0) ? 1 : 0));
      check_val("q_ackb", 32'(AckB), 32'(((j % 2) == 1) ? 1 : 0));
      if (AckA) DatA = DatA + 8'd1;
      if (AckB) DatB = DatB + 8'd1;
    end
    ReqA = 1'b0; ReqB = 1'b0;
    wait_idle("q_idle");
    check_val("q_bank3", 32'(bank[3]), 32'h14);
    check_val("q_bank5", 32'(bank[5]), 32'h84);

    // Back-pressure on B while A holds priority
    do_reset();
    ReqA = 1'b1; AddrA = 3'd1; DatA = 8'h21;
    ReqB = 1'b1; AddrB = 3'd7; DatB = 8'h71;
    tick();
    check_val("b_acka0", 32'(AckA), 32'd1);
    check_val("b_ackb0", 32'(AckB), 32'd1);
    DatA = 8'h22; DatB = 8'h72;
    tick();
    check_val("b_acka1", 32'(AckA), 32'd1);
    check_val("b_ackb1", 32'(AckB), 32'd0);
    check_val("b_dat1",  32'(Dat),  32'h21);
    ReqA = 1'b0; DatB = 8'h73;
    tick();
    check_val("b_acka2", 32'(AckA), 32'd0);
    check_val("b_ackb2", 32'(AckB), 32'd1);
    check_val("b_rw2",   32'(R_W),  32'd7);
    check_val("b_dat2",  32'(Dat),  32'h71);
    ReqB = 1'b0;
    tick();
    check_val("b_ackb3", 32'(AckB), 32'd0);
    check_val("b_dat3",  32'(Dat),  32'h22);
    tick();
    check_val("b_dat4",  32'(Dat),  32'h73);
    wait_idle("b_idle");
    check_val("b_bank7", 32'(bank[7]), 32'h73);
    check_val("b_bank1", 32'(bank[1]), 32'h22);

    // Asynchronous reset with both buffers full and a write on the port
    do_reset();
    ReqA = 1'b1; AddrA = 3'd5; DatA = 8'hAA;
    ReqB = 1'b1; AddrB = 3'd6; DatB = 8'hBB;
    tick();
    DatA = 8'hAC;
    tick();
    check_val("r_en1",   32'(E_N),  32'd1);
    check_val("r_pend1", 32'(Pend), 32'h60);
    check_val("r_busy1", 32'(Busy), 32'd1);
    #2;
    Rst = 1'b1;
    #1;
    check_val("r_en",   32'(E_N),  32'd0);
    check_val("r_acka", 32'(AckA), 32'd0);
    check_val("r_ackb", 32'(AckB), 32'd0);
    check_val("r_pend", 32'(Pend), 32'd0);
    check_val("r_busy", 32'(Busy), 32'd0);
    ReqA = 1'b0; ReqB = 1'b0;
    tick();
    Rst = 1'b0;
    tick();
    tick();
    check_val("r_bank5", 32'(bank[5]), 32'h84);
    check_val("r_bank6", 32'(bank[6]), 32'd3);
    check_val("r_en2",   32'(E_N), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
